// File: rtl/fft_framer_if.sv
// Sample-stream / parallel-frame bus between an upstream source and fft_input_framer.
// master: source side (drives samples, sees ready and frames); slave: the framer.
interface fft_framer_if #(
    parameter int N      = 8,
    parameter int DATA_W = 16
);
    logic                     s_valid_i;
    logic signed [DATA_W-1:0] s_data_i;
    logic                     s_ready_o;
    logic                     valid_o;
    logic signed [DATA_W-1:0] x_re_o [0:N-1];

    modport master (output s_valid_i, s_data_i, input s_ready_o, valid_o, x_re_o);
    modport slave  (input s_valid_i, s_data_i, output s_ready_o, valid_o, x_re_o);
endinterface

// File: rtl/fft_input_framer.sv
// fft_input_framer: collects a serial Q1.15 sample stream into N-sample frames using
// ping-pong banks and presents each finished frame in parallel with a one-cycle valid
// pulse, never closer than MIN_GAP cycles apart.
// Optional feature macro: FFT_FRAMER_BITREV_EN -- samples are stored at the bit-reversed
// bank location, giving bit-reversed order on x_re_o for a DIT core.
module fft_input_framer #(
    parameter int N       = 8,
    parameter int DATA_W  = 16,
    parameter int MIN_GAP = 20
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    fft_framer_if.slave  bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int GAP_W = $clog2(MIN_GAP + 1);

    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("fft_input_framer: N must be a power of two >= 2");
    end
    if (MIN_GAP < 1) begin : g_bad_gap
        $error("fft_input_framer: MIN_GAP must be >= 1");
    end

    logic signed [DATA_W-1:0] bank_q [2][N];
    logic                     wr_bank_q;
    logic [IDX_W-1:0]         wr_idx_q;
    logic                     full_q;
    logic                     valid_q;
    logic [GAP_W-1:0]         gap_q;

    logic                     accept;
    logic                     complete;
    logic                     swap;
    logic                     rd_bank;
    logic [IDX_W-1:0]         wr_addr;

    function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] i);
        logic [IDX_W-1:0] r;
        for (int b = 0; b < IDX_W; b++) r[b] = i[IDX_W-1-b];
        return r;
    endfunction

    // Ready depends only on registered state, so the source never sees a comb loop.
    assign accept   = bus.s_valid_i && !full_q;
    assign complete = (accept && wr_idx_q == IDX_W'(N - 1)) || full_q;
    assign swap     = complete && (gap_q == '0);
    assign rd_bank  = ~wr_bank_q;

`ifdef FFT_FRAMER_BITREV_EN
    assign wr_addr = bitrev(wr_idx_q);
`else
    assign wr_addr = wr_idx_q;
`endif

    assign bus.s_ready_o = !full_q;
    assign bus.valid_o   = valid_q;

    // Control: write index, bank select, stall flag, frame pulse and spacing counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_idx_q  <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= 1'b0;
            valid_q   <= 1'b0;
            gap_q     <= '0;
        end else begin
            valid_q <= swap;
            if (accept) wr_idx_q <= wr_idx_q + IDX_W'(1);
            if (swap) begin
                wr_bank_q <= ~wr_bank_q;
                full_q    <= 1'b0;
                gap_q     <= GAP_W'(MIN_GAP - 1);
            end else begin
                if (complete) full_q <= 1'b1;
                if (gap_q != '0) gap_q <= gap_q - GAP_W'(1);
            end
        end
    end

    // Sample storage: only the write bank is ever written; the read bank stays frozen.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < 2; b++)
                for (int j = 0; j < N; j++)
                    bank_q[b][j] <= '0;
        end else if (accept) begin
            bank_q[wr_bank_q][wr_addr] <= bus.s_data_i;
        end
    end

    // Parallel frame output straight from the read bank.
    always_comb begin
        for (int j = 0; j < N; j++) bus.x_re_o[j] = bank_q[rd_bank][j];
    end
endmodule
